// File: rtl/inv_stream_pkg.sv
// Shared definitions for the inverting stream stage: transform mode encodings.
package inv_stream_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_INV  = 2'b01,
    MODE_MASK = 2'b10,
    MODE_ALT  = 2'b11
  } mode_e;

endpackage

// File: rtl/inv_stream_fifo.sv
// Generic WIDTH x DEPTH synchronous FIFO with full/empty flags and async active-high reset.
module inv_stream_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign full  = (occ_q == FULL_OCC);
  assign empty = (occ_q == '0);
  assign do_wr = wr_en & ~full;
  assign do_rd = rd_en & ~empty;
  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/inv_stream_stage.sv
// Registered streaming stage applying a per-beat selectable bit inversion, with an output
// buffer and a saturating count of inverted beats.
module inv_stream_stage
  import inv_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             mask_load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] inv_count
);

  logic [WIDTH-1:0] mask_q;
  logic             phase_q;
  logic [WIDTH-1:0] eff_mask;
  logic             full, empty, accept, pop;
  mode_e            mode_sel;

  assign mode_sel  = mode_e'(mode);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    eff_mask = '0;
    unique case (mode_sel)
      MODE_PASS: eff_mask = '0;
      MODE_INV:  eff_mask = '1;
      MODE_MASK: eff_mask = mask_q;
      MODE_ALT:  eff_mask = phase_q ? '0 : '1;
      default:   eff_mask = '0;
    endcase
  end

  // A mask load coinciding with an accept takes effect only for later beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= '0;
      phase_q   <= 1'b0;
      inv_count <= '0;
    end else begin
      if (mask_load) mask_q <= mask_in;
      if (accept && (mode_sel == MODE_ALT)) phase_q <= ~phase_q;
      if (accept && (eff_mask != '0) && (inv_count != '1)) inv_count <= inv_count + 1'b1;
    end
  end

  inv_stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_data (in_data ^ eff_mask),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_inv_stream_stage.sv
// Self-checking bench: directed vector table, hand sequences and random traffic against a
// queue-based reference model.
module tb_inv_stream_stage;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] mask_in = 8'h00;
  logic       mask_load = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, s_in_ready, s_out_valid;
  logic [7:0] out_data, s_out_data;
  logic [15:0] inv_count;
  logic [1:0]  s_inv_count;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic [7:0] m_mask;
  bit         m_phase;
  int         m_cnt;

  always #5 clk = ~clk;

  inv_stream_stage #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .mask_in(mask_in), .mask_load(mask_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .inv_count(inv_count)
  );

  inv_stream_stage #(.WIDTH(8), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .mode(mode), .mask_in(mask_in), .mask_load(mask_load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready), .out_data(s_out_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .inv_count(s_inv_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model_eff(input logic [1:0] md);
    case (md)
      2'd0: return 8'h00;
      2'd1: return 8'hFF;
      2'd2: return m_mask;
      default: return m_phase ? 8'h00 : 8'hFF;
    endcase
  endfunction

  task automatic check_model();
    int exp_sat;
    exp_sat = (m_cnt > 3) ? 3 : m_cnt;
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_data", out_data, (mq.size() > 0) ? mq[0] : 8'h00);
    chk("in_ready", in_ready, mq.size() < DEPTH);
    chk("inv_count", inv_count, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("sat_count", s_inv_count, exp_sat);
  endtask

  // One clock with the currently driven inputs; model advanced, then everything checked.
  task automatic cycle();
    bit acc, pp;
    logic [7:0] e;
    acc = in_valid && (mq.size() < DEPTH);
    pp  = (mq.size() > 0) && out_ready;
    e   = model_eff(mode);
    @(posedge clk);
    #1;
    if (pp) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(in_data ^ e);
      if (e != 8'h00) m_cnt++;
      if (mode == 2'd3) m_phase = ~m_phase;
    end
    if (mask_load) m_mask = mask_in;
    check_model();
  endtask

  // Asserted while aligned just after an edge, so reset effects are seen between edges.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    m_mask = 8'h00;
    m_phase = 1'b0;
    m_cnt = 0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_inv_count", inv_count, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [7:0] mask_in;
    logic       mask_load;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_cnt;
  } vec_t;

  vec_t vecs[8];
  int   sat_exp[5];

  initial begin
    vecs[0] = '{2'd1, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'h5A, 1};
    vecs[1] = '{2'd3, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 8'hF0, 2};
    vecs[2] = '{2'd3, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h0F, 2};
    vecs[3] = '{2'd3, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 8'hF0, 3};
    vecs[4] = '{2'd3, 8'h00, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b1, 8'h0F, 3};
    vecs[5] = '{2'd2, 8'h81, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 3};
    vecs[6] = '{2'd2, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h81, 4};
    vecs[7] = '{2'd0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 4};
    sat_exp = '{1, 2, 3, 3, 3};

    @(posedge clk);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
      mask_in = vecs[i].mask_in;
      mask_load = vecs[i].mask_load;
      in_data = vecs[i].data;
      in_valid = vecs[i].valid;
      out_ready = vecs[i].ready;
      cycle();
      chk("vec_valid", out_valid, vecs[i].exp_valid);
      chk("vec_data", out_data, vecs[i].exp_data);
      chk("vec_count", inv_count, vecs[i].exp_cnt);
    end
    mask_load = 1'b0;

    // Backpressure: third beat is held off while full, then all drain in order.
    do_reset();
    mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h11; cycle(); chk("bp_ready1", in_ready, 1'b1);
    in_data = 8'h22; cycle(); chk("bp_ready2", in_ready, 1'b0);
    in_data = 8'h33; cycle(); chk("bp_hold", out_data, 8'h11);
    out_ready = 1'b1;
    cycle(); chk("bp_drain1", out_data, 8'h22);
    cycle(); chk("bp_drain2", out_data, 8'h33);
    in_valid = 1'b0;
    cycle(); chk("bp_empty", out_valid, 1'b0);

    // Saturation of the narrow counter.
    do_reset();
    mode = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'($urandom);
      cycle();
      chk("sat_seq", s_inv_count, sat_exp[i]);
    end

    // Asynchronous reset with two beats buffered, then a fresh beat.
    do_reset();
    mode = 2'd0; out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hAA; cycle();
    in_data = 8'hBB; cycle();
    in_valid = 1'b0;
    do_reset();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    cycle(); chk("post_rst_data", out_data, 8'h3C);
    in_valid = 1'b0;
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      mode = 2'($urandom);
      mask_in = 8'($urandom);
      mask_load = ($urandom_range(0, 3) == 0);
      in_data = 8'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
